// File: rtl/ptcalc_mul_pipe.sv
// Pipelined signed multiplier with valid tagging, clock-enable stall and
// round-half-up scaling with saturate-or-wrap to the output width.
module ptcalc_mul_pipe #(
  parameter int unsigned ID         = 1,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned din0_WIDTH = 15,
  parameter int unsigned din1_WIDTH = 15,
  parameter int unsigned dout_WIDTH = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         din_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         dout_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int unsigned PW = din0_WIDTH + din1_WIDTH;

  // ID only tags the instance; it has no functional effect
  localparam int unsigned unused_id = ID;

  localparam logic [PW:0] RND_ADD = ((PW+1)'(1) << SHIFT) >> 1;
  localparam logic signed [PW:0] MAXV =
    {{(PW-dout_WIDTH+2){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(PW-dout_WIDTH+2){1'b1}}, {(dout_WIDTH-1){1'b0}}};
  localparam logic [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]         prod_c;
  logic signed [PW-1:0]         scale_p;
  logic                         scale_vld;
  logic signed [PW:0]           rnd_sum;
  logic signed [PW:0]           r_full;
  logic                         ovf_c;
  logic signed [dout_WIDTH-1:0] dout_c;

  assign prod_c = PW'(din0) * PW'(din1);

  // Full product is registered ahead of the scaling logic when depth allows
  if (NUM_STAGE == 1) begin : g_direct
    assign scale_vld = din_valid;
    assign scale_p   = prod_c;
  end else begin : g_piped
    localparam int unsigned NP = NUM_STAGE - 1;
    logic [NP-1:0]        pv_q;
    logic signed [PW-1:0] pp_q [NP];

    for (genvar s = 0; s < NP; s++) begin : g_stage
      logic                 in_v;
      logic signed [PW-1:0] in_p;

      if (s == 0) begin : g_first
        assign in_v = din_valid;
        assign in_p = prod_c;
      end else begin : g_next
        assign in_v = pv_q[s-1];
        assign in_p = pp_q[s-1];
      end

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          pv_q[s] <= 1'b0;
        end else if (ce) begin
          pv_q[s] <= in_v;
        end
      end

      // Data loads only behind a valid token
      always_ff @(posedge ap_clk) begin
        if (ce && in_v) begin
          pp_q[s] <= in_p;
        end
      end
    end

    assign scale_vld = pv_q[NP-1];
    assign scale_p   = pp_q[NP-1];
  end

  // Round half up at PW+1 bits, then range-check against the dout bounds
  always_comb begin
    rnd_sum = {scale_p[PW-1], scale_p} + RND_ADD;
    r_full  = rnd_sum >>> SHIFT;
    ovf_c   = (r_full > MAXV) || (r_full < MINV);
    dout_c  = r_full[dout_WIDTH-1:0];
    if (SATURATE != 0 && ovf_c) begin
      dout_c = r_full[PW] ? DMIN : DMAX;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      ovf        <= 1'b0;
    end else if (ce) begin
      dout_valid <= scale_vld;
      if (scale_vld) begin
        dout <= dout_c;
        ovf  <= ovf_c;
      end
    end
  end

endmodule
